// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// Holds the arbiter FSM state encoding and the default channel header base.
// Imported by uart_tx_arbiter; rr_arbiter is parameter-only and needs nothing here.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_HDR  = 3'd1,
    WAIT_HDR  = 3'd2,
    SEND_DATA = 3'd3,
    WAIT_DATA = 3'd4
  } arb_state_t;

  // Header byte sent ahead of each payload is HDR_BASE | requester index.
  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: one-hot grant to the first requester after last_grant.
// Latency: purely combinational, no state held here.
// Backpressure: none; the caller decides whether the grant is actually taken.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] cand;
  logic           found;

  // Walk from last_grant+1 upward with wrap; the first pending requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters, optionally prefixing a channel header byte.
// Latency: accept-to-trigger 1 cycle; o_done one cycle after the payload's i_tx_done.
// Backpressure: grants only in IDLE while the transmitter is idle; o_req_ready is the one-hot accept.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter int         PAYLOAD_BITS = 8,
  parameter int         HDR_EN       = 1,
  parameter logic [7:0] HDR_BASE     = HDR_BASE_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] i_req_data,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic                            o_tx_trig,
  output logic [PAYLOAD_BITS-1:0]         o_tx_data,
  input  logic                            i_tx_busy,
  input  logic                            i_tx_done,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [$clog2(NUM_REQ)-1:0]      o_done_id
);

  localparam int IDW = $clog2(NUM_REQ);

  arb_state_t              state_q, state_d;
  logic [IDW-1:0]          last_grant_q;
  logic [IDW-1:0]          idx_q;
  logic [IDW-1:0]          win_idx;
  logic [PAYLOAD_BITS-1:0] data_q;
  logic [PAYLOAD_BITS-1:0] win_data;
  logic [PAYLOAD_BITS-1:0] hdr_byte;
  logic [NUM_REQ-1:0]      rr_grant;
  logic                    grant_en;
  logic                    done_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req        (i_req_valid),
    .last_grant (last_grant_q),
    .grant      (rr_grant)
  );

  // Decode the one-hot winner into an index and pick out its byte.
  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_grant[i]) begin
        win_idx  = IDW'(i);
        win_data = i_req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  assign hdr_byte = PAYLOAD_BITS'(HDR_BASE) | PAYLOAD_BITS'(idx_q);
  assign o_busy   = (state_q != IDLE);

  // Next-state and per-state outputs; ready is forced low while reset is held.
  always_comb begin
    state_d     = state_q;
    grant_en    = 1'b0;
    done_d      = 1'b0;
    o_req_ready = '0;
    o_tx_trig   = 1'b0;
    o_tx_data   = '0;
    case (state_q)
      IDLE: begin
        if (reset_n && (|i_req_valid) && !i_tx_busy) begin
          grant_en    = 1'b1;
          o_req_ready = rr_grant;
          state_d     = (HDR_EN != 0) ? SEND_HDR : SEND_DATA;
        end
      end
      SEND_HDR: begin
        o_tx_trig = 1'b1;
        o_tx_data = hdr_byte;
        state_d   = WAIT_HDR;
      end
      WAIT_HDR: begin
        o_tx_data = hdr_byte;
        if (i_tx_done) state_d = SEND_DATA;
      end
      SEND_DATA: begin
        o_tx_trig = 1'b1;
        o_tx_data = data_q;
        state_d   = WAIT_DATA;
      end
      WAIT_DATA: begin
        o_tx_data = data_q;
        if (i_tx_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the grant/latch and completion-pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      idx_q        <= '0;
      data_q       <= '0;
      o_done       <= 1'b0;
      o_done_id    <= '0;
    end else begin
      state_q <= state_d;
      o_done  <= done_d;
      if (done_d) o_done_id <= idx_q;
      if (grant_en) begin
        last_grant_q <= win_idx;
        idx_q        <= win_idx;
        data_q       <= win_data;
      end
    end
  end

endmodule
